// File: rtl/time_multiplexer.sv
// Two-digit time multiplexer: alternately lights display 0 and display 1 with a
// dark gap between them, feeding a shared seven-segment decoder.
//
// state  | meaning
// DIGIT0 | display 0 lit, value holds value0 latched on entry
// BLANK0 | both displays dark after display 0
// DIGIT1 | display 1 lit, value holds value1 latched on entry
// BLANK1 | both displays dark after display 1; idle state for reset/disable
module time_multiplexer #(
   parameter int unsigned HOLD_CYCLES  = 12000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] value0,
   input  logic [3:0] value1,
   output logic [3:0] value,
   output logic [1:0] digit_en_n,
   output logic       frame_tick
);

   typedef enum logic [1:0] {
      DIGIT0 = 2'd0,
      BLANK0 = 2'd1,
      DIGIT1 = 2'd2,
      BLANK1 = 2'd3
   } state_e;

   localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [3:0]  value_q, value_d;
   logic [1:0]  digit_en_n_q, digit_en_n_d;
   logic        frame_tick_q, frame_tick_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= BLANK1;
         cnt_q        <= '0;
         value_q      <= 4'h0;
         digit_en_n_q <= 2'b11;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         value_q      <= value_d;
         digit_en_n_q <= digit_en_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   // Dwell counter restarts on every state change; a low enable parks the FSM
   // at the start of BLANK1 regardless of any transition due on this edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 24'd1;
      if (!enable) begin
         state_d = BLANK1;
         cnt_d   = '0;
      end else begin
         case (state_q)
            DIGIT0: if (cnt_q == HOLD_LAST) begin
               state_d = BLANK0;
               cnt_d   = '0;
            end
            BLANK0: if (cnt_q == BLANK_LAST) begin
               state_d = DIGIT1;
               cnt_d   = '0;
            end
            DIGIT1: if (cnt_q == HOLD_LAST) begin
               state_d = BLANK1;
               cnt_d   = '0;
            end
            BLANK1: if (cnt_q == BLANK_LAST) begin
               state_d = DIGIT0;
               cnt_d   = '0;
            end
            default: begin
               state_d = BLANK1;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs follow the next state so they are registered alongside it.
   always_comb begin
      value_d      = value_q;
      digit_en_n_d = 2'b11;
      frame_tick_d = 1'b0;
      case (state_d)
         DIGIT0:  digit_en_n_d = 2'b10;
         DIGIT1:  digit_en_n_d = 2'b01;
         default: digit_en_n_d = 2'b11;
      endcase
      if (state_d != state_q) begin
         if (state_d == DIGIT0) begin
            value_d      = value0;
            frame_tick_d = 1'b1;
         end else if (state_d == DIGIT1) begin
            value_d = value1;
         end
      end
   end

   assign value      = value_q;
   assign digit_en_n = digit_en_n_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/time_multiplexer.md
TIME_MULTIPLEXER -- requirements
Module: time_multiplexer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  HOLD_CYCLES  12000  clocks each digit is lit; legal range 2..2^24-1
  BLANK_CYCLES  64  clocks both digits are dark between digits; legal range 1..2^24-1
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single system clock; all state updates on its rising edge
  reset  input  1  asynchronous, active-low reset
  enable  input  1  high = multiplex; low = display dark
  value0  input  4  hex digit for display 0
  value1  input  4  hex digit for display 1
  value  output  4  digit code to the downstream seven_segment_display decoder
  digit_en_n  output  2  active-low common-anode enables; bit0 = display 0, bit1 = display 1
  frame_tick  output  1  one-cycle pulse at the start of each frame
REQ-003 All outputs SHALL be registered, with no combinational path from input to output.

Function
REQ-004 The FSM SHALL have four states, cycling in this order: DIGIT0 -> BLANK0 -> DIGIT1 -> BLANK1 -> DIGIT0.
REQ-005 A 24-bit dwell counter SHALL clear on every state entry and increment each cycle.
REQ-006 The FSM SHALL leave a DIGIT state on the edge where the counter equals HOLD_CYCLES-1.
REQ-007 The FSM SHALL leave a BLANK state on the edge where the counter equals BLANK_CYCLES-1.
REQ-008 The frame period SHALL be exactly 2*(HOLD_CYCLES+BLANK_CYCLES) clocks.
REQ-009 On the DIGIT0 entry edge:
  - value <= value0 as sampled on that edge
  - digit_en_n <= 2'b10
  - frame_tick <= 1
REQ-010 On the DIGIT1 entry edge:
  - value <= value1 as sampled on that edge
  - digit_en_n <= 2'b01
REQ-011 Within a DIGIT state, value SHALL stay fixed; changes to value0/value1 appear only at the next entry of the matching DIGIT state.
REQ-012 In BLANK0 and BLANK1:
  - digit_en_n SHALL be 2'b11
  - value SHALL keep its last value
REQ-013 frame_tick SHALL be 0 on every cycle except the one following the DIGIT0 entry edge.
REQ-014 digit_en_n SHALL never equal 2'b00 on any cycle.
REQ-015 When enable is sampled low on an edge:
  - the FSM goes to BLANK1 with the counter cleared
  - digit_en_n <= 2'b11
  - frame_tick <= 0
  - value is held
  - this overrides any transition due on that same edge
REQ-016 While enable stays low, the FSM SHALL remain in BLANK1 with the counter held at 0.
REQ-017 After enable returns high, the FSM SHALL enter DIGIT0 on the BLANK_CYCLES-th rising edge on which enable is sampled high.
REQ-018 The counter SHALL never wrap; parameter legality guarantees it stays in range.

Reset
REQ-019 Asserting reset (low) SHALL immediately, with no clock edge, force:
  - state = BLANK1, counter = 0
  - value = 4'h0
  - digit_en_n = 2'b11
  - frame_tick = 0
REQ-020 Reset asserted in any state, including mid-DIGIT, SHALL abandon the current frame.
REQ-021 After reset deasserts, the FSM SHALL enter DIGIT0 on the BLANK_CYCLES-th rising edge, provided enable is high.

Verification
REQ-022 The bench SHALL use HOLD_CYCLES=4 and BLANK_CYCLES=2, and cover these scenarios:
  - Reset sequence: value0=4'h3, value1=4'hA, enable=1, release reset -> edge 2: en=10, value=3, frame_tick=1; edge 3: frame_tick=0; edge 6: en=11; edge 8: en=01, value=A; edge 12: en=11; edge 14: en=10, frame_tick=1. Period = 12.
  - Input stability: value0 changes 3->7 one cycle after the DIGIT0 entry edge -> value stays 3 until the next DIGIT0 entry, then becomes 7.
  - Reset mid-DIGIT1 (between edges) -> en=11, value=0, frame_tick=0 before the next edge; after release, DIGIT0 at edge 2.
  - Enable drop: enable low for 3 cycles during DIGIT0 -> en=11 on the first low-sampling edge and held; DIGIT0 re-entered 2 edges after enable is sampled high, with frame_tick=1.
  - Enable low on the same edge a DIGIT0->BLANK0 transition is due -> state goes to BLANK1 (not BLANK0), en=11.
  - Free run over at least 100 frames with random value0/value1 -> assert digit_en_n != 00 every cycle; frame_tick count equals frame count; each displayed value matches the input sampled at its entry edge.
